// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

   // Controller sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Upper bound on operand width accepted by the controller.
   localparam int unsigned MAX_WIDTH = 32;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting datapath and serial_add_ctrl.
interface serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   // Requester side: issues operands, observes status and result.
   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   // Controller side: consumes operands, produces status and result.
   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf
   );

endinterface : serial_add_ctrl_if

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell shared by the serial controller.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (c & (a ^ b));

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder step per clock, LSB first,
// with registered sum, carry-out, signed overflow and a one-cycle done pulse.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_add_ctrl_if.slave  bus
);

   localparam int unsigned          CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]     LAST_STEP = CNT_W'(WIDTH - 1);

   if ((WIDTH < 2) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
      $error("serial_add_ctrl: WIDTH must be within 2..%0d", MAX_WIDTH);
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cout;
   logic             r_ovf;
   logic             r_busy;
   logic             r_done;

   logic             w_fa_sum;
   logic             w_fa_carry;

   full_adder u_full_adder (
      .a     (r_a[0]),
      .b     (r_b[0]),
      .c     (r_carry),
      .sum   (w_fa_sum),
      .carry (w_fa_carry)
   );

   // Sequencer: latch operands, step the full adder WIDTH times, pulse done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_carry <= bus.cin;
                  r_cnt   <= '0;
                  r_sum   <= '0;
                  r_cout  <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
               r_carry <= w_fa_carry;
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_STEP) begin
                  // r_carry is the carry into the MSB on this final step
                  r_cout  <= w_fa_carry;
                  r_ovf   <= r_carry ^ w_fa_carry;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
   assign bus.ovf  = r_ovf;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH 8, 3 and 5.
module tb_serial_add_ctrl;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int unsigned checks = 0;
   int unsigned errors = 0;

   exp_t q8[$];
   exp_t q3[$];
   exp_t q5[$];

   always #5 clk = ~clk;

   serial_add_ctrl_if #(.WIDTH(8)) if8 ();
   serial_add_ctrl_if #(.WIDTH(3)) if3 ();
   serial_add_ctrl_if #(.WIDTH(5)) if5 ();

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   serial_add_ctrl #(.WIDTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
   serial_add_ctrl #(.WIDTH(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

   // Reference: {cout,sum} = a + b + cin modulo 2^w, signed overflow from sign bits.
   function automatic exp_t model(input int unsigned w, input logic [31:0] a,
                                  input logic [31:0] b, input logic cin);
      logic [33:0] full;
      logic [31:0] mask;
      logic [31:0] am;
      logic [31:0] bm;
      exp_t        e;
      mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      am     = a & mask;
      bm     = b & mask;
      full   = {2'b00, am} + {2'b00, bm} + {33'd0, cin};
      e.sum  = full[31:0] & mask;
      e.cout = full[w];
      e.ovf  = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
      return e;
   endfunction

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input string tag);
      exp_t        e;
      int unsigned cyc;
      int unsigned busy_cnt;
      @(negedge clk);
      if8.a = a; if8.b = b; if8.cin = cin; if8.start = 1'b1;
      q8.push_back(model(8, {24'd0, a}, {24'd0, b}, cin));
      cyc = 0; busy_cnt = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) if8.start = 1'b0;
         if (if8.busy) busy_cnt++;
      end while (!if8.done && cyc < 40);
      e = q8.pop_front();
      checks++;
      if (if8.done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", tag, if8.done, cyc);
      end else begin
         checks++;
         if (cyc !== 9) begin
            errors++;
            $display("FAIL %s_latency: done seen %0d cycles after drive, required 9", tag, cyc);
         end
         checks++;
         if (busy_cnt !== 8) begin
            errors++;
            $display("FAIL %s_busy_len: busy high %0d cycles, required 8", tag, busy_cnt);
         end
         checks++;
         if ({if8.cout, if8.sum, if8.ovf} !== {e.cout, e.sum[7:0], e.ovf}) begin
            errors++;
            $display("FAIL %s_result: cout=%b sum=%h ovf=%b, required cout=%b sum=%h ovf=%b",
                     tag, if8.cout, if8.sum, if8.ovf, e.cout, e.sum[7:0], e.ovf);
         end
         @(negedge clk);
         checks++;
         if ({if8.done, if8.busy} !== 2'b00) begin
            errors++;
            $display("FAIL %s_pulse: done=%b busy=%b one cycle after done, required 0 0",
                     tag, if8.done, if8.busy);
         end
         checks++;
         if ({if8.cout, if8.sum, if8.ovf} !== {e.cout, e.sum[7:0], e.ovf}) begin
            errors++;
            $display("FAIL %s_hold: cout=%b sum=%h ovf=%b, required cout=%b sum=%h ovf=%b",
                     tag, if8.cout, if8.sum, if8.ovf, e.cout, e.sum[7:0], e.ovf);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({if8.busy, if8.done, if8.sum, if8.cout, if8.ovf} !== 12'd0) begin
         errors++;
         $display("FAIL reset_w8: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                  if8.busy, if8.done, if8.sum, if8.cout, if8.ovf);
      end
      checks++;
      if ({if3.busy, if3.done, if3.sum, if3.cout, if3.ovf} !== 7'd0) begin
         errors++;
         $display("FAIL reset_w3: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                  if3.busy, if3.done, if3.sum, if3.cout, if3.ovf);
      end
      checks++;
      if ({if5.busy, if5.done, if5.sum, if5.cout, if5.ovf} !== 9'd0) begin
         errors++;
         $display("FAIL reset_w5: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                  if5.busy, if5.done, if5.sum, if5.cout, if5.ovf);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      run8(8'h5A, 8'h3C, 1'b0, "add_5a_3c");
      run8(8'hFF, 8'h01, 1'b0, "add_ff_01");
      run8(8'h7F, 8'h00, 1'b1, "add_7f_cin");
      for (int i = 0; i < 4; i++) begin
         run8(8'($urandom), 8'($urandom), 1'($urandom), "add_rand");
      end
   endtask

   task automatic test_ignored_start;
      exp_t        e;
      int unsigned dones;
      @(negedge clk);
      if8.a = 8'h11; if8.b = 8'h22; if8.cin = 1'b0; if8.start = 1'b1;
      q8.push_back(model(8, 32'h11, 32'h22, 1'b0));
      dones = 0;
      for (int cyc = 1; cyc <= 22; cyc++) begin
         @(negedge clk);
         if (cyc == 1) if8.start = 1'b0;
         if (cyc == 3) begin if8.start = 1'b1; if8.a = 8'hFF; end
         if (cyc == 4) if8.start = 1'b0;
         if (if8.done) begin
            dones++;
            if (dones == 1) begin
               e = q8.pop_front();
               checks++;
               if ({if8.cout, if8.sum, if8.ovf} !== {e.cout, e.sum[7:0], e.ovf}) begin
                  errors++;
                  $display("FAIL ignored_start_result: cout=%b sum=%h ovf=%b, required cout=%b sum=%h ovf=%b",
                           if8.cout, if8.sum, if8.ovf, e.cout, e.sum[7:0], e.ovf);
               end
            end
         end
      end
      if (dones == 0) e = q8.pop_front();
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL ignored_start_dones: %0d done pulses, required 1", dones);
      end
   endtask

   task automatic test_reset_abort;
      int unsigned dones;
      @(negedge clk);
      if8.a = 8'hAA; if8.b = 8'h55; if8.cin = 1'b0; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({if8.busy, if8.done, if8.sum, if8.cout, if8.ovf} !== 12'd0) begin
         errors++;
         $display("FAIL abort_async: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                  if8.busy, if8.done, if8.sum, if8.cout, if8.ovf);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (15) begin
         @(negedge clk);
         if (if8.done) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL abort_no_done: %0d done pulses after abort, required 0", dones);
      end
      run8(8'h01, 8'h01, 1'b0, "after_abort");
   endtask

   task automatic test_exhaustive_w3;
      exp_t        e;
      int unsigned cyc;
      int unsigned waited;
      int unsigned prev;
      @(negedge clk);
      if3.a = 3'd0; if3.b = 3'd0; if3.cin = 1'b0; if3.start = 1'b1;
      q3.push_back(model(3, 32'd0, 32'd0, 1'b0));
      cyc = 0; prev = 0;
      for (int i = 0; i < 128; i++) begin
         waited = 0;
         do begin
            @(negedge clk);
            cyc++;
            waited++;
         end while (!if3.done && waited < 20);
         e = q3.pop_front();
         checks++;
         if (if3.done !== 1'b1) begin
            errors++;
            $display("FAIL w3_timeout: combo %0d done=%b after %0d cycles, required 1", i, if3.done, waited);
            if3.start = 1'b0;
            break;
         end
         checks++;
         if ({if3.cout, if3.sum, if3.ovf} !== {e.cout, e.sum[2:0], e.ovf}) begin
            errors++;
            $display("FAIL w3_result: combo %0d cout=%b sum=%h ovf=%b, required cout=%b sum=%h ovf=%b",
                     i, if3.cout, if3.sum, if3.ovf, e.cout, e.sum[2:0], e.ovf);
         end
         if (i > 0) begin
            checks++;
            if (cyc - prev !== 5) begin
               errors++;
               $display("FAIL w3_spacing: combo %0d done spacing %0d cycles, required 5", i, cyc - prev);
            end
         end
         prev = cyc;
         if (i < 127) begin
            if3.a   = 3'((i + 1) & 7);
            if3.b   = 3'(((i + 1) >> 3) & 7);
            if3.cin = 1'(((i + 1) >> 6) & 1);
            q3.push_back(model(3, {29'd0, if3.a}, {29'd0, if3.b}, if3.cin));
         end else begin
            if3.start = 1'b0;
         end
      end
      q3.delete();
   endtask

   task automatic test_w5;
      exp_t        e;
      int unsigned cyc;
      @(negedge clk);
      if5.a = 5'h1F; if5.b = 5'h1F; if5.cin = 1'b1; if5.start = 1'b1;
      q5.push_back(model(5, 32'h1F, 32'h1F, 1'b1));
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) if5.start = 1'b0;
      end while (!if5.done && cyc < 30);
      e = q5.pop_front();
      checks++;
      if (cyc !== 6 || if5.done !== 1'b1) begin
         errors++;
         $display("FAIL w5_latency: done=%b at %0d cycles after drive, required 1 at 6", if5.done, cyc);
      end
      checks++;
      if ({if5.cout, if5.sum, if5.ovf} !== {e.cout, e.sum[4:0], e.ovf}) begin
         errors++;
         $display("FAIL w5_result: cout=%b sum=%h ovf=%b, required cout=%b sum=%h ovf=%b",
                  if5.cout, if5.sum, if5.ovf, e.cout, e.sum[4:0], e.ovf);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
      if3.start = 1'b0; if3.a = '0; if3.b = '0; if3.cin = 1'b0;
      if5.start = 1'b0; if5.a = '0; if5.b = '0; if5.cin = 1'b0;
      test_reset();
      test_basic();
      test_ignored_start();
      test_reset_abort();
      test_exhaustive_w3();
      test_w5();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_serial_add_ctrl
